exe_fp_addsub: RTL and testbench

Execute-stage single-precision floating-point adder/subtractor for FADD.S / FSUB.S. Consumes the two operand words read from the FP register file in ID, which arrive through the ID/EXE register. Runs a fixed 4-cycle multi-cycle FSM and holds the pipeline via `stall` while busy. Produces an IEEE-754 binary32 result, rounded to nearest-even, for the MEM/WB path back to the FP register file.

---
 rtl/exe_fp_addsub.sv | 171 +++++++++++++++++
 tb/tb_exe_fp_addsub.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/exe_fp_addsub.sv
// Execute-stage binary32 FADD.S/FSUB.S: fixed ALIGN -> ADD -> NORM -> DONE sequence,
// round-to-nearest-even, subnormals flushed; holds the pipeline through `stall` while busy.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module exe_fp_addsub (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [`DATA_WIDTH-1:0] rs1_FP_data,
  input  logic [`DATA_WIDTH-1:0] rs2_FP_data,
  output logic                   busy,
  output logic                   stall,
  output logic                   done,
  output logic [`DATA_WIDTH-1:0] fp_result
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;
  state_t state, next_state;

  logic        launch;
  logic [31:0] opa, opb;
  logic        sub_q;
  logic [26:0] sig_l_q, sig_s_q;
  logic [7:0]  exp_q;
  logic        sign_q, eff_sub_q, neg_zero_q, spec_q;
  logic [31:0] spec_val_q;
  logic [27:0] sum_q;

  assign launch = start && (state == IDLE || state == DONE);
  assign stall  = busy | launch;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = ALIGN;
      ALIGN:   next_state = ADD;
      ADD:     next_state = NORM;
      NORM:    next_state = DONE;
      DONE:    next_state = start ? ALIGN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand decode and alignment, all from the latched operands.
  logic [7:0]  ea, eb, exp_l, exp_s, diff;
  logic        sa, sb, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, swap;
  logic [23:0] sig_a, sig_b;
  logic [26:0] ext_s, shifted, mask, aligned;
  logic        spec, sticky;
  logic [31:0] spec_val;

  assign ea     = opa[30:23];
  assign eb     = opb[30:23];
  assign sa     = opa[31];
  assign sb     = opb[31] ^ sub_q;
  assign a_zero = (ea == 8'd0);
  assign b_zero = (eb == 8'd0);
  assign a_inf  = (ea == 8'hFF) && (opa[22:0] == 23'd0);
  assign b_inf  = (eb == 8'hFF) && (opb[22:0] == 23'd0);
  assign a_nan  = (ea == 8'hFF) && (opa[22:0] != 23'd0);
  assign b_nan  = (eb == 8'hFF) && (opb[22:0] != 23'd0);
  assign sig_a  = a_zero ? 24'd0 : {1'b1, opa[22:0]};
  assign sig_b  = b_zero ? 24'd0 : {1'b1, opb[22:0]};
  // Flushed operands compare as zero so a subnormal never wins the swap.
  assign swap   = (b_zero ? 31'd0 : opb[30:0]) > (a_zero ? 31'd0 : opa[30:0]);
  assign exp_l  = swap ? eb : ea;
  assign exp_s  = swap ? ea : eb;
  assign diff   = exp_l - exp_s;
  assign ext_s  = {swap ? sig_a : sig_b, 3'b000};

  always_comb begin
    shifted = ext_s >> diff[4:0];
    mask    = (27'd1 << diff[4:0]) - 27'd1;
    sticky  = |(ext_s & mask);
    if (diff >= 8'd27) aligned = {26'd0, |ext_s};
    else               aligned = {shifted[26:1], shifted[0] | sticky};
  end

  always_comb begin
    spec     = 1'b1;
    spec_val = 32'h7FC00000;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) spec_val = 32'h7FC00000;
    else if (a_inf) spec_val = {sa, 8'hFF, 23'd0};
    else if (b_inf) spec_val = {sb, 8'hFF, 23'd0};
    else            spec     = 1'b0;
  end

  // Normalise and round from the ADD-stage sum.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++) if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  logic [4:0]  lz;
  logic [26:0] m;
  logic [9:0]  e1, e2;
  logic        up;
  logic [24:0] rsum;
  logic [22:0] frac;
  logic [31:0] res;

  always_comb begin
    lz = lzc27(sum_q[26:0]);
    if (sum_q[27]) begin
      m  = {sum_q[27:2], sum_q[1] | sum_q[0]};
      e1 = {2'b00, exp_q} + 10'd1;
    end else begin
      m  = sum_q[26:0] << lz;
      e1 = {2'b00, exp_q} - {5'd0, lz};
    end
    up   = m[2] & (m[1] | m[0] | m[3]);
    rsum = {1'b0, m[26:3]} + {24'd0, up};
    frac = rsum[24] ? rsum[23:1] : rsum[22:0];
    e2   = e1 + {9'd0, rsum[24]};
    if (spec_q)                            res = spec_val_q;
    else if (sum_q == 28'd0)               res = {neg_zero_q, 31'd0};
    else if (!e2[9] && e2 >= 10'd255)      res = {sign_q, 8'hFF, 23'd0};
    else if (e2[9] || e2 == 10'd0)         res = {sign_q, 31'd0};
    else                                   res = {sign_q, e2[7:0], frac};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      fp_result  <= '0;
      opa        <= '0;
      opb        <= '0;
      sub_q      <= 1'b0;
      sig_l_q    <= '0;
      sig_s_q    <= '0;
      exp_q      <= '0;
      sign_q     <= 1'b0;
      eff_sub_q  <= 1'b0;
      neg_zero_q <= 1'b0;
      spec_q     <= 1'b0;
      spec_val_q <= '0;
      sum_q      <= '0;
    end else begin
      state <= next_state;
      busy  <= (next_state == ALIGN) || (next_state == ADD) || (next_state == NORM);
      done  <= (next_state == DONE);
      if (launch) begin
        opa   <= rs1_FP_data;
        opb   <= rs2_FP_data;
        sub_q <= op_sub;
      end
      if (state == ALIGN) begin
        sig_l_q    <= {swap ? sig_b : sig_a, 3'b000};
        sig_s_q    <= aligned;
        exp_q      <= exp_l;
        sign_q     <= swap ? sb : sa;
        eff_sub_q  <= sa ^ sb;
        neg_zero_q <= sa & sb;
        spec_q     <= spec;
        spec_val_q <= spec_val;
      end
      if (state == ADD)
        sum_q <= eff_sub_q ? {1'b0, sig_l_q} - {1'b0, sig_s_q}
                           : {1'b0, sig_l_q} + {1'b0, sig_s_q};
      if (state == NORM) fp_result <= res;
    end
  end

endmodule

// File: tb/tb_exe_fp_addsub.sv
// Directed bench for exe_fp_addsub: vector table plus handshake and reset sequences.
module tb_exe_fp_addsub;

  logic        clk = 1'b0;
  logic        rst, start, op_sub;
  logic [31:0] rs1, rs2;
  logic        busy, stall, done;
  logic [31:0] fp_result;

  int checks = 0;
  int errors = 0;

  exe_fp_addsub dut (
    .clk(clk), .rst(rst), .start(start), .op_sub(op_sub),
    .rs1_FP_data(rs1), .rs2_FP_data(rs2),
    .busy(busy), .stall(stall), .done(done), .fp_result(fp_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Launch one op from IDLE/DONE; return result and cycles until done (-1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        output logic [31:0] res, output int lat);
    @(negedge clk);
    rs1 = a; rs2 = b; op_sub = s; start = 1'b1;
    #1 check("stall_launch", {31'd0, stall}, 32'd1);
    lat = -1;
    res = 32'hDEADBEEF;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      if (done) begin
        lat = c;
        res = fp_result;
        check("stall_done", {31'd0, stall}, 32'd0);
        break;
      end
      check("stall_busy", {31'd0, stall}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] r, r1, r2;
    int lat, n, t1, t2, s1;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000};
    vecs[2]  = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000};
    vecs[3]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000};
    vecs[4]  = '{32'h3F800000, 32'h33C00000, 1'b0, 32'h3F800001};
    vecs[5]  = '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF};
    vecs[6]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000};
    vecs[7]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000};
    vecs[8]  = '{32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000};
    vecs[9]  = '{32'h00000001, 32'h3F800000, 1'b0, 32'h3F800000};
    vecs[10] = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000};
    vecs[11] = '{32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000};
    vecs[12] = '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000};
    vecs[13] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000};
    vecs[14] = '{32'h40000000, 32'h40000000, 1'b0, 32'h40800000};

    rst = 1'b1; start = 1'b0; op_sub = 1'b0; rs1 = '0; rs2 = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", fp_result, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, r, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].exp);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
    end

    // start pulses while busy must be ignored.
    @(negedge clk);
    rs1 = 32'h40400000; rs2 = 32'h3F800000; op_sub = 1'b1; start = 1'b1;
    n = 0; t1 = -1; r1 = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin rs1 = 32'h7FC00000; rs2 = 32'h7FC00000; op_sub = 1'b0; end
      if (c == 4) start = 1'b0;
      #1;
      if (done) begin
        n++;
        if (n == 1) begin t1 = c; r1 = fp_result; end
      end
    end
    check("ignore_done_count", 32'(n), 32'd1);
    check("ignore_done_cycle", 32'(t1), 32'd4);
    check("ignore_result", r1, 32'h40000000);

    // start held through DONE launches a second op back-to-back.
    @(negedge clk);
    rs1 = 32'h3F800000; rs2 = 32'h40000000; op_sub = 1'b0; start = 1'b1;
    n = 0; t1 = -1; t2 = -1; s1 = -1; r1 = '0; r2 = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 1) begin rs1 = 32'h40000000; rs2 = 32'h40000000; end
      if (c == 5) start = 1'b0;
      #1;
      if (done) begin
        n++;
        if (n == 1) begin t1 = c; r1 = fp_result; s1 = int'(stall); end
        else if (n == 2) begin t2 = c; r2 = fp_result; end
      end
    end
    check("b2b_done_count", 32'(n), 32'd2);
    check("b2b_first_cycle", 32'(t1), 32'd4);
    check("b2b_first_result", r1, 32'h40400000);
    check("b2b_stall_in_done", 32'(s1), 32'd1);
    check("b2b_second_cycle", 32'(t2), 32'd8);
    check("b2b_second_result", r2, 32'h40800000);

    // Reset asserted in the ADD cycle aborts the op.
    @(negedge clk);
    rs1 = 32'h3F800000; rs2 = 32'h40000000; op_sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_result", fp_result, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      #1;
      if (done) n++;
    end
    check("midrst_no_done", 32'(n), 32'd0);
    run_op(32'h40000000, 32'h40000000, 1'b0, r, lat);
    check("postrst_result", r, 32'h40800000);
    check("postrst_latency", 32'(lat), 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
